// File: rtl/data_memory_ctrl.sv
// Clocked byte-addressable data memory with req/ready handshake, programmable wait states and error reporting.
// Latency: WAIT_STATES+2 cycles from req to ready; requests are only accepted in IDLE or RESP (ignored while busy).
module data_memory_ctrl #(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  busy,
  output logic                  ready,
  output logic [31:0]           rdata,
  output logic                  err
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state;
  state_t                nextState;
  logic [3:0]            waitCnt;
  logic [3:0]            waitCntNext;
  logic                  accept;
  logic                  doAccess;

  logic                  opWe;
  logic [1:0]            opSize;
  logic                  opSignExt;
  logic [ADDR_WIDTH-1:0] opAddr;
  logic [31:0]           opWdata;
  logic                  errReg;

  logic [31:0]           mem [DEPTH_WORDS] = '{default: 32'h0};

  logic [IDX_W-1:0]      wordIdx;
  logic                  outOfRange;
  logic                  misaligned;
  logic                  reject;
  logic [3:0]            laneEn;
  logic [31:0]           storeData;
  logic [31:0]           rdWord;
  logic [7:0]            byteSel;
  logic [15:0]           halfSel;
  logic [31:0]           loadVal;

  always_comb begin
    nextState   = state;
    waitCntNext = waitCnt;
    accept      = 1'b0;
    doAccess    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept      = 1'b1;
          nextState   = WAIT;
          waitCntNext = WAIT_CNT;
        end
      end
      WAIT: begin
        if (waitCnt == 4'd0) begin
          doAccess  = 1'b1;
          nextState = RESP;
        end else begin
          waitCntNext = waitCnt - 4'd1;
        end
      end
      RESP: begin
        if (req) begin
          accept      = 1'b1;
          nextState   = WAIT;
          waitCntNext = WAIT_CNT;
        end else begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign busy  = (state == WAIT);
  assign ready = (state == RESP);
  assign err   = ready & errReg;

  // Everything below decodes the latched request, so it is stable through WAIT.
  assign wordIdx    = opAddr[IDX_W+1:2];
  assign outOfRange = |opAddr[ADDR_WIDTH-1:IDX_W+2];

  always_comb begin
    misaligned = 1'b0;
    laneEn     = 4'b0000;
    storeData  = opWdata;
    case (opSize)
      2'b00: begin
        laneEn    = 4'b0001 << opAddr[1:0];
        storeData = {4{opWdata[7:0]}};
      end
      2'b01: begin
        misaligned = opAddr[0];
        laneEn     = opAddr[1] ? 4'b1100 : 4'b0011;
        storeData  = {2{opWdata[15:0]}};
      end
      2'b10: begin
        misaligned = |opAddr[1:0];
        laneEn     = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  assign reject = misaligned | outOfRange;

  assign rdWord  = mem[wordIdx];
  assign byteSel = rdWord[{opAddr[1:0], 3'b000} +: 8];
  assign halfSel = opAddr[1] ? rdWord[31:16] : rdWord[15:0];

  always_comb begin
    loadVal = rdWord;
    case (opSize)
      2'b00:   loadVal = {{24{opSignExt & byteSel[7]}}, byteSel};
      2'b01:   loadVal = {{16{opSignExt & halfSel[15]}}, halfSel};
      default: loadVal = rdWord;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      waitCnt   <= 4'd0;
      errReg    <= 1'b0;
      rdata     <= 32'h0;
      opWe      <= 1'b0;
      opSize    <= 2'b00;
      opSignExt <= 1'b0;
      opAddr    <= '0;
      opWdata   <= 32'h0;
    end else begin
      state   <= nextState;
      waitCnt <= waitCntNext;
      if (accept) begin
        opWe      <= we;
        opSize    <= size;
        opSignExt <= sign_ext;
        opAddr    <= addr;
        opWdata   <= wdata;
      end
      if (doAccess) begin
        errReg <= reject;
        if (!opWe && !reject) begin
          rdata <= loadVal;
        end
      end
    end
  end

  // Storage survives reset; while Reset is high the FSM sits in IDLE so no write can fire.
  always_ff @(posedge CLK) begin
    if (doAccess && opWe && !reject) begin
      for (int k = 0; k < 4; k++) begin
        if (laneEn[k]) begin
          mem[wordIdx][8*k +: 8] <= storeData[8*k +: 8];
        end
      end
    end
  end

endmodule
